// File: rtl/attempt_lockout_controller.sv
// Password attempt sequencer: unlock on match, timed lockout with BCD countdown after MAX_FAIL misses.
// Optional LOCKOUT_ESCALATE_EN: each successive lockout doubles its duration, capped at 99 s.
module attempt_lockout_controller #(
  parameter int unsigned CLK_HZ   = 50000000,
  parameter int unsigned MAX_FAIL = 3,
  parameter int unsigned LOCK_SEC = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       check_req,
  input  logic       match,
  input  logic       relock,
  output logic       buttons_enable,
  output logic       unlocked,
  output logic       locked_out,
  output logic       alarm,
  output logic [2:0] fail_count,
  output logic [3:0] remain_tens,
  output logic [3:0] remain_ones
);

  localparam int unsigned       TICK_W     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(CLK_HZ - 1);
  localparam logic [3:0]        MAX_FAIL_N = 4'(MAX_FAIL);
  localparam logic [2:0]        MAX_FAIL_3 = 3'(MAX_FAIL);

  typedef enum logic [1:0] {IDLE, UNLOCKED, LOCKOUT} state_t;

  state_t            state, state_nx;
  logic [TICK_W-1:0] tick_cnt, tick_nx;
  logic [2:0]        fail_nx;
  logic              unl_nx, lo_nx, al_nx, be_nx;
  logic [3:0]        tens_nx, ones_nx;
  logic [7:0]        load_bcd;
  logic              fail_limit;

  function automatic logic [7:0] to_bcd(input int unsigned secs);
    return {4'(secs / 10), 4'(secs % 10)};
  endfunction

  assign fail_limit = ({1'b0, fail_count} + 4'd1) >= MAX_FAIL_N;

`ifdef LOCKOUT_ESCALATE_EN
  logic [2:0]  lock_cnt, lock_cnt_inc;
  int unsigned esc_secs;

  always_comb begin
    lock_cnt_inc = (lock_cnt == 3'd7) ? 3'd7 : lock_cnt + 3'd1;
    esc_secs     = LOCK_SEC << (lock_cnt_inc - 3'd1);
    if (esc_secs > 99) esc_secs = 99;
    load_bcd     = to_bcd(esc_secs);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt <= '0;
    end else if (state == IDLE && check_req) begin
      if (match)           lock_cnt <= '0;
      else if (fail_limit) lock_cnt <= lock_cnt_inc;
    end
  end
`else
  assign load_bcd = to_bcd(LOCK_SEC);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      tick_cnt       <= '0;
      fail_count     <= '0;
      unlocked       <= 1'b0;
      locked_out     <= 1'b0;
      alarm          <= 1'b0;
      buttons_enable <= 1'b1;
      remain_tens    <= '0;
      remain_ones    <= '0;
    end else begin
      state          <= state_nx;
      tick_cnt       <= tick_nx;
      fail_count     <= fail_nx;
      unlocked       <= unl_nx;
      locked_out     <= lo_nx;
      alarm          <= al_nx;
      buttons_enable <= be_nx;
      remain_tens    <= tens_nx;
      remain_ones    <= ones_nx;
    end
  end

  always_comb begin
    state_nx = state;
    tick_nx  = tick_cnt;
    fail_nx  = fail_count;
    unl_nx   = unlocked;
    lo_nx    = locked_out;
    al_nx    = 1'b0;
    be_nx    = buttons_enable;
    tens_nx  = remain_tens;
    ones_nx  = remain_ones;
    case (state)
      IDLE: begin
        if (check_req) begin
          if (match) begin
            state_nx = UNLOCKED;
            fail_nx  = '0;
            unl_nx   = 1'b1;
          end else if (!fail_limit) begin
            fail_nx = fail_count + 3'd1;
          end else begin
            state_nx           = LOCKOUT;
            fail_nx            = MAX_FAIL_3;
            al_nx              = 1'b1;
            be_nx              = 1'b0;
            lo_nx              = 1'b1;
            {tens_nx, ones_nx} = load_bcd;
            tick_nx            = '0;
          end
        end
      end
      UNLOCKED: begin
        if (relock) begin
          state_nx = IDLE;
          unl_nx   = 1'b0;
        end
      end
      LOCKOUT: begin
        if (tick_cnt == TICK_LAST) begin
          tick_nx = '0;
          // Expiry fires on the tick that would take 01 to 00, so lockout spans LOCK_SEC full seconds.
          if (remain_tens == 4'd0 && remain_ones == 4'd1) begin
            state_nx = IDLE;
            fail_nx  = '0;
            lo_nx    = 1'b0;
            be_nx    = 1'b1;
            tens_nx  = '0;
            ones_nx  = '0;
          end else if (remain_ones == 4'd0) begin
            ones_nx = 4'd9;
            tens_nx = remain_tens - 4'd1;
          end else begin
            ones_nx = remain_ones - 4'd1;
          end
        end else begin
          tick_nx = tick_cnt + TICK_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_attempt_lockout_controller.sv
// Directed scoreboard bench for attempt_lockout_controller (CLK_HZ=10, MAX_FAIL=3, LOCK_SEC=12).
module tb_attempt_lockout_controller;

  localparam int unsigned CLK_HZ   = 10;
  localparam int unsigned MAX_FAIL = 3;
  localparam int unsigned LOCK_SEC = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       check_req = 1'b0, match = 1'b0, relock = 1'b0;
  logic       buttons_enable, unlocked, locked_out, alarm;
  logic [2:0] fail_count;
  logic [3:0] remain_tens, remain_ones;

  typedef struct {
    string      tag;
    logic       be, unl, lo, al;
    logic [2:0] fc;
    logic [3:0] t, o;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          failed = 0;
  int unsigned lock_n = 0;
  int unsigned secs;

  attempt_lockout_controller #(
    .CLK_HZ  (CLK_HZ),
    .MAX_FAIL(MAX_FAIL),
    .LOCK_SEC(LOCK_SEC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .check_req     (check_req),
    .match         (match),
    .relock        (relock),
    .buttons_enable(buttons_enable),
    .unlocked      (unlocked),
    .locked_out    (locked_out),
    .alarm         (alarm),
    .fail_count    (fail_count),
    .remain_tens   (remain_tens),
    .remain_ones   (remain_ones)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input string tag, input logic be, input logic unl, input logic lo,
                              input logic al, input logic [2:0] fc, input logic [3:0] t,
                              input logic [3:0] o);
    exp_t e;
    e.tag = tag; e.be = be; e.unl = unl; e.lo = lo; e.al = al; e.fc = fc; e.t = t; e.o = o;
    return e;
  endfunction

  function automatic int unsigned lock_secs(input int unsigned n);
    int unsigned s;
`ifdef LOCKOUT_ESCALATE_EN
    s = LOCK_SEC << (n - 1);
    if (s > 99) s = 99;
`else
    s = LOCK_SEC + 0 * n;
`endif
    return s;
  endfunction

  task automatic cmp(input string tag, input string name, input logic [3:0] got, input logic [3:0] want);
    tests++;
    assert (got === want)
    else begin
      failed++;
      $error("FAIL %s.%s got %0h want %0h", tag, name, got, want);
    end
  endtask

  task automatic check_front();
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      failed++;
      $display("FAIL scoreboard_empty got 0 entries want 1");
      return;
    end
    e = sb.pop_front();
    cmp(e.tag, "buttons_enable", {3'b0, buttons_enable}, {3'b0, e.be});
    cmp(e.tag, "unlocked",       {3'b0, unlocked},       {3'b0, e.unl});
    cmp(e.tag, "locked_out",     {3'b0, locked_out},     {3'b0, e.lo});
    cmp(e.tag, "alarm",          {3'b0, alarm},          {3'b0, e.al});
    cmp(e.tag, "fail_count",     {1'b0, fail_count},     {1'b0, e.fc});
    cmp(e.tag, "remain_tens",    remain_tens,            e.t);
    cmp(e.tag, "remain_ones",    remain_ones,            e.o);
  endtask

  task automatic step(input logic cr, input logic m, input logic rl, input exp_t e);
    @(negedge clk);
    check_req = cr; match = m; relock = rl;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_req = 1'b0; match = 1'b0; relock = 1'b0;
    check_front();
  endtask

  task automatic enter_lockout(output int unsigned s);
    step(1'b1, 1'b0, 1'b0, mk("miss1", 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 4'd0, 4'd0));
    step(1'b1, 1'b0, 1'b0, mk("miss2", 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 4'd0, 4'd0));
    lock_n = (lock_n >= 7) ? 7 : lock_n + 1;
    s = lock_secs(lock_n);
    step(1'b1, 1'b0, 1'b0, mk("lock_entry", 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 4'(s / 10), 4'(s % 10)));
  endtask

  task automatic run_lockout(input int unsigned s, input int unsigned stop_at);
    int unsigned rem;
    logic        inj;
    for (int unsigned j = 1; j <= stop_at; j++) begin
      inj = (j == 35);
      if (j < s * CLK_HZ) begin
        rem = s - j / CLK_HZ;
        step(inj, inj, inj, mk(inj ? "lockout_ignore_req" : "lockout_tick", 1'b0, 1'b0, 1'b1, 1'b0,
                               3'd3, 4'(rem / 10), 4'(rem % 10)));
      end else begin
        step(inj, inj, inj, mk("lockout_end", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0));
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    sb.push_back(mk("reset", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0));
    check_front();
    @(negedge clk);
    rst_n = 1'b1;

    step(1'b1, 1'b1, 1'b0, mk("match_unlock",     1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0));
    step(1'b1, 1'b0, 1'b0, mk("unl_ignore_check", 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0));
    step(1'b0, 1'b0, 1'b1, mk("relock",           1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0));
    step(1'b1, 1'b0, 1'b1, mk("idle_check_wins",  1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 4'd0, 4'd0));
    step(1'b0, 1'b0, 1'b1, mk("relock_keeps_fc",  1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 4'd0, 4'd0));
    step(1'b1, 1'b0, 1'b0, mk("miss_to_2",        1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 4'd0, 4'd0));
    step(1'b1, 1'b1, 1'b0, mk("match_clears",     1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0));
    lock_n = 0;
    step(1'b1, 1'b0, 1'b1, mk("unl_relock_wins",  1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0));

    enter_lockout(secs);
    run_lockout(secs, secs * CLK_HZ);
    step(1'b0, 1'b0, 1'b0, mk("idle_after_lock",  1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0));

    enter_lockout(secs);
    run_lockout(secs, secs * CLK_HZ);

    step(1'b1, 1'b1, 1'b0, mk("match_after_lock", 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0));
    lock_n = 0;
    step(1'b0, 1'b0, 1'b1, mk("relock2",          1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0));

    enter_lockout(secs);
    run_lockout(secs, 50);

    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    sb.push_back(mk("async_reset", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0));
    check_front();
    lock_n = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b0, mk("match_post_reset", 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
